// File: rtl/fft_bitrev_reorder.sv
// Bit-reversal reorder buffer for a 512-point SDF FFT: ping-pong RAM takes
// bit-reversed frames and replays them in natural bin order through a skid FIFO.
module fft_bitrev_reorder #(
    parameter int WIDTH = 32,
    parameter int LOG2N = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic             do_ready,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG2N-1:0] do_idx,
    output logic             do_last,
    output logic             ovf
);
    localparam int N  = 1 << LOG2N;
    localparam int DW = 2 * WIDTH;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {IDLE, READ} rd_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [LOG2N-1:0] idx;
    } out_word_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [DW-1:0]    mem [2*N];
    logic [DW-1:0]    rdata;

    logic [LOG2N-1:0] wcnt;
    logic             wbank;
    logic             wdrop;
    logic [1:0]       full;
    logic [1:0]       full_next;

    rd_state_t        state;
    logic             rbank;
    logic [LOG2N-1:0] rcnt;
    logic             rd_pending;
    logic [LOG2N-1:0] rd_idx;

    out_word_t        fifo [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic             frame_start;
    logic             bank_busy;
    logic             drop_now;
    logic             wr_en;
    logic             frame_end;
    logic             push;
    logic             pop;
    logic [2:0]       load;
    logic             rd_issue;
    logic             release_bank;

    // A frame is accepted or rejected as a whole, decided on its first sample.
    assign frame_start = di_en && (wcnt == '0);
    assign bank_busy   = full[wbank] || (state == READ && rbank == wbank);
    assign drop_now    = frame_start ? bank_busy : wdrop;
    assign wr_en       = di_en && !drop_now;
    assign frame_end   = wr_en && (wcnt == LAST);

    // Occupancy counts the sample leaving this cycle so a steady stream never bubbles.
    assign push         = rd_pending;
    assign pop          = do_en && do_ready;
    assign load         = {1'b0, count} + {2'b0, rd_pending} - {2'b0, pop};
    assign rd_issue     = (load < 3'd2) && (state == READ || full[rbank]);
    assign release_bank = rd_issue && (state == READ) && (rcnt == LAST);

    // NOTE: always_comb starts from a full default so no path can infer a latch.
    always_comb begin
        full_next = full;
        if (release_bank) full_next[rbank] = 1'b0;
        if (frame_end)    full_next[wbank] = 1'b1;
    end

    // NOTE: the sample RAM has no reset; every word is rewritten before it is read.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) mem[{wbank, bitrev(wcnt)}] <= {di_re, di_im};
        if (rd_issue)        rdata <= mem[{rbank, rcnt}];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt       <= '0;
            wbank      <= 1'b0;
            wdrop      <= 1'b0;
            full       <= 2'b00;
            ovf        <= 1'b0;
            state      <= IDLE;
            rbank      <= 1'b0;
            rcnt       <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (di_en) begin
                wcnt <= wcnt + LOG2N'(1);
                if (frame_start) wdrop <= bank_busy;
                if (frame_end)   wbank <= ~wbank;
            end
            if (frame_start && bank_busy) ovf <= 1'b1;
            full <= full_next;

            case (state)
                IDLE: begin
                    if (rd_issue) begin
                        state <= READ;
                        rcnt  <= rcnt + LOG2N'(1);
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        if (rcnt == LAST) begin
                            rbank <= ~rbank;
                            rcnt  <= '0;
                            state <= full[!rbank] ? READ : IDLE;
                        end else begin
                            rcnt <= rcnt + LOG2N'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            rd_pending <= rd_issue;
            if (rd_issue) rd_idx <= rcnt;

            if (push) begin
                fifo[wr_ptr] <= {rdata, rd_idx};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign do_en   = (count != 2'd0);
    assign do_re   = fifo[rd_ptr].re;
    assign do_im   = fifo[rd_ptr].im;
    assign do_idx  = fifo[rd_ptr].idx;
    assign do_last = do_en && (fifo[rd_ptr].idx == LAST);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: scenario table plus reset sequences,
// checked against a frame-level model of bit-reversed-to-natural reordering.
module tb_fft_bitrev_reorder;
    localparam int WIDTH = 32;
    localparam int LOG2N = 9;
    localparam int N     = 1 << LOG2N;

    logic             clock = 1'b0;
    logic             reset;
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_ready;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic [LOG2N-1:0] do_idx;
    logic             do_last;
    logic             ovf;

    fft_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clock    (clock),
        .reset    (reset),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_ready (do_ready),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_idx   (do_idx),
        .do_last  (do_last),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [LOG2N-1:0] idx;
    } exp_t;

    typedef struct {
        string    name;
        int       nframes;
        int       gap;
        int       ready_pct;
        bit [3:0] drop_mask;
        bit       pat;
        int       exp_frames;
        bit       exp_ovf;
        bit       cont;
        bit       lat;
    } row_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    int   bubbles = 0;
    bit   out_started = 0;
    bit   ovf_exp = 0;
    int   ready_pct = 100;

    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_re;
    logic [WIDTH-1:0] prev_im;
    logic [LOG2N-1:0] prev_idx;
    logic             prev_last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position k of a bit-reversed stream carries bin whose index is k read backwards.
    function automatic int rev_index(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    initial begin
        do_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            do_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", 128'({do_en, do_re, do_im, do_idx, do_last}),
                      128'({1'b1, prev_re, prev_im, prev_idx, prev_last}));
            if (do_en) out_started = 1;
            else if (out_started && exp_q.size() != 0) bubbles++;
            if (do_en && do_ready) begin
                out_count++;
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 128'({do_re, do_im}), 128'({e.re, e.im}));
                    check("out_idx_last", 128'({do_idx, do_last}),
                          128'({e.idx, (int'(e.idx) == N - 1)}));
                end
            end
            prev_stall = do_en && !do_ready;
            prev_re    = do_re;
            prev_im    = do_im;
            prev_idx   = do_idx;
            prev_last  = do_last;
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        di_en = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_outputs", 128'({do_en, do_re, do_im, do_idx, do_last, ovf}), 128'(0));
        out_count   = 0;
        bubbles     = 0;
        out_started = 0;
        ovf_exp     = 0;
    endtask

    // Called just after a rising edge; returns just after the edge accepting the last sample.
    task automatic send_frame(input int nsamp, input int gap, input bit drop, input bit pat);
        logic [WIDTH-1:0] nat_re [N];
        logic [WIDTH-1:0] nat_im [N];
        for (int k = 0; k < nsamp; k++) begin
            logic [WIDTH-1:0] re;
            logic [WIDTH-1:0] im;
            int bin;
            bin = rev_index(k);
            if (pat) begin
                re = WIDTH'(bin);
                im = ~WIDTH'(bin);
            end else begin
                re = $urandom;
                im = $urandom;
            end
            nat_re[bin] = re;
            nat_im[bin] = im;
            if (k > 0) repeat (gap) begin
                @(posedge clock);
                #1;
            end
            di_en = 1'b1;
            di_re = re;
            di_im = im;
            @(posedge clock);
            #1;
            di_en = 1'b0;
            if (k == 0) begin
                ovf_exp = ovf_exp | drop;
                check("ovf_at_frame_start", 128'(ovf), 128'(ovf_exp));
            end
        end
        if (nsamp == N && !drop)
            for (int b = 0; b < N; b++) exp_q.push_back('{nat_re[b], nat_im[b], LOG2N'(b)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_remaining", 128'(exp_q.size()), 128'(0));
        repeat (8) @(negedge clock);
    endtask

    initial begin
        row_t rows [5];
        rows[0] = '{"single_bitrev",    1, 0, 100, 4'b0000, 1'b1, 1, 1'b0, 1'b1, 1'b1};
        rows[1] = '{"four_back2back",   4, 0, 100, 4'b0000, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        rows[2] = '{"random_ready",     2, 0,  50, 4'b0000, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        rows[3] = '{"stalled_overflow", 3, 0,   0, 4'b0100, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        rows[4] = '{"gapped_input",     2, 2, 100, 4'b0000, 1'b1, 2, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (3) @(posedge clock);
        #1;

        for (int r = 0; r < 5; r++) begin
            ready_pct = rows[r].ready_pct;
            do_reset();
            for (int f = 0; f < rows[r].nframes; f++)
                send_frame(N, rows[r].gap, rows[r].drop_mask[f], rows[r].pat);
            if (rows[r].lat) begin
                @(negedge clock);
                check({rows[r].name, "_lat_edge0"}, 128'(do_en), 128'(0));
                @(negedge clock);
                check({rows[r].name, "_lat_edge1"}, 128'(do_en), 128'(0));
                @(negedge clock);
                check({rows[r].name, "_lat_edge2"}, 128'(do_en), 128'(1));
            end
            if (rows[r].ready_pct == 0) ready_pct = 100;
            wait_drain();
            check({rows[r].name, "_out_count"}, 128'(out_count), 128'(rows[r].exp_frames * N));
            check({rows[r].name, "_ovf"}, 128'(ovf), 128'(rows[r].exp_ovf));
            if (rows[r].cont) check({rows[r].name, "_bubbles"}, 128'(bubbles), 128'(0));
        end

        // Reset after 200 samples of a frame, then a clean frame.
        ready_pct = 100;
        do_reset();
        send_frame(200, 0, 1'b0, 1'b0);
        do_reset();
        send_frame(N, 0, 1'b0, 1'b0);
        wait_drain();
        check("after_midframe_reset_count", 128'(out_count), 128'(N));

        // Reset in the middle of an output frame, then a clean frame.
        do_reset();
        send_frame(N, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2000 && out_count < 100; i++) @(negedge clock);
        check("mid_output_reached", 128'(out_count >= 100), 128'(1));
        do_reset();
        send_frame(N, 0, 1'b0, 1'b1);
        wait_drain();
        check("after_midoutput_reset_count", 128'(out_count), 128'(N));
        check("after_midoutput_reset_ovf", 128'(ovf), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
